// File: rtl/sync_freq_monitor_if.sv
// rtl/sync_freq_monitor_if.sv - sync input, fault clear and monitor status bundle (high_time present with SYNC_MON_DUTY_EN)
interface sync_freq_monitor_if #(
  parameter int CW = 16
);
  logic          sync_in;
  logic          fault_clr;
  logic          locked;
  logic          fault;
  logic [CW-1:0] period;
  logic          period_vld;
  logic [7:0]    err_cnt;
`ifdef SYNC_MON_DUTY_EN
  logic [CW-1:0] high_time;

  modport master (
    output sync_in, fault_clr,
    input  locked, fault, period, period_vld, err_cnt, high_time
  );
  modport slave (
    input  sync_in, fault_clr,
    output locked, fault, period, period_vld, err_cnt, high_time
  );
`else
  modport master (
    output sync_in, fault_clr,
    input  locked, fault, period, period_vld, err_cnt
  );
  modport slave (
    input  sync_in, fault_clr,
    output locked, fault, period, period_vld, err_cnt
  );
`endif
endinterface

// File: rtl/sync_freq_monitor.sv
// rtl/sync_freq_monitor.sv - converter sync clock period monitor with lock/fault; SYNC_MON_DUTY_EN adds high_time
module sync_freq_monitor #(
  parameter int CW         = 16,
  parameter int NOM_PERIOD = 67,
  parameter int MIN_PERIOD = 60,
  parameter int MAX_PERIOD = 74,
  parameter int LOCK_CNT   = 8
) (
  input logic                clk,
  input logic                rst,
  sync_freq_monitor_if.slave io_bus
);
  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACQUIRE = 2'd1,
    S_LOCKED  = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_sync_meta;
  logic          r_sync_s;
  logic          r_sync_d;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_good_cnt;
  logic          r_locked;
  logic          r_fault;
  logic [7:0]    r_err_cnt;
  logic [CW-1:0] r_period;
  logic          r_period_vld;

  logic w_rise;
  logic w_timeout;
  logic w_good;
  logic w_clear;
  logic w_measure;

  assign w_rise    = r_sync_s & ~r_sync_d;
  assign w_timeout = (r_cnt == CW'(MAX_PERIOD + 1)) & ~w_rise;
  assign w_good    = (r_cnt >= CW'(MIN_PERIOD)) && (r_cnt <= CW'(MAX_PERIOD));
  // A clear in FAULT takes priority over any coincident edge, which is then not measured
  assign w_clear   = (r_state == S_FAULT) & io_bus.fault_clr;
  // cnt==0 marks "no start edge yet", so the first rise only arms the counter
  assign w_measure = w_rise & (r_cnt != '0) & ~w_clear;

  // Two-flop synchronizer plus one delayed copy for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_meta <= 1'b0;
      r_sync_s    <= 1'b0;
      r_sync_d    <= 1'b0;
    end else begin
      r_sync_meta <= io_bus.sync_in;
      r_sync_s    <= r_sync_meta;
      r_sync_d    <= r_sync_s;
    end
  end

  // Cycles since the last rise; idles at 0 until armed, saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_clear || ((r_state == S_ACQUIRE) && w_timeout)) begin
      r_cnt <= '0;
    end else if (w_rise) begin
      r_cnt <= CW'(1);
    end else if ((r_cnt != '0) && !(&r_cnt)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Publish the period on each measured edge with a one-cycle valid pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period     <= CW'(NOM_PERIOD);
      r_period_vld <= 1'b0;
    end else begin
      r_period_vld <= w_measure;
      if (w_measure) begin
        r_period <= r_cnt;
      end
    end
  end

  // Lock/fault state machine with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_good_cnt <= '0;
      r_locked   <= 1'b0;
      r_fault    <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state    <= S_ACQUIRE;
            r_good_cnt <= '0;
          end
        end
        S_ACQUIRE: begin
          if (w_rise) begin
            if (w_good) begin
              r_good_cnt <= r_good_cnt + GW'(1);
              if (r_good_cnt == GW'(LOCK_CNT - 1)) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
              end
            end else begin
              r_good_cnt <= '0;
            end
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        S_LOCKED: begin
          if ((w_rise && !w_good) || w_timeout) begin
            r_state  <= S_FAULT;
            r_locked <= 1'b0;
            r_fault  <= 1'b1;
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
          end
        end
        S_FAULT: begin
          if (io_bus.fault_clr) begin
            r_state    <= S_IDLE;
            r_fault    <= 1'b0;
            r_good_cnt <= '0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_locked <= 1'b0;
          r_fault  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYNC_MON_DUTY_EN
  logic [CW-1:0] r_high_cnt;
  logic [CW-1:0] r_high_time;

  // High-cycle count per period; the rise cycle itself is already high, hence restart at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_cnt  <= '0;
      r_high_time <= '0;
    end else begin
      if (w_rise) begin
        r_high_cnt <= CW'(1);
      end else if (r_sync_s && !(&r_high_cnt)) begin
        r_high_cnt <= r_high_cnt + CW'(1);
      end
      if (w_measure) begin
        r_high_time <= r_high_cnt;
      end
    end
  end

  assign io_bus.high_time = r_high_time;
`endif

  assign io_bus.locked     = r_locked;
  assign io_bus.fault      = r_fault;
  assign io_bus.period     = r_period;
  assign io_bus.period_vld = r_period_vld;
  assign io_bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_sync_freq_monitor.sv
// tb/tb_sync_freq_monitor.sv - self-checking bench: timestamp-based reference model plus directed and random sync patterns
module tb_sync_freq_monitor;
  localparam int CW    = 16;
  localparam int NOM   = 67;
  localparam int MINP  = 60;
  localparam int MAXP  = 74;
  localparam int LOCKN = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_freq_monitor_if #(.CW(CW)) bus();

  sync_freq_monitor #(
    .CW(CW), .NOM_PERIOD(NOM), .MIN_PERIOD(MINP), .MAX_PERIOD(MAXP), .LOCK_CNT(LOCKN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 acquire, 2 locked, 3 fault; rises are
  // time-stamped by edge number and the period is the difference of stamps.
  int n_edge = 0;
  int last_rise = 0;
  bit started = 0;
  int mode = 0;
  int good = 0;
  int m_err = 0;
  int m_period = NOM;
  bit m_vld = 0;
  int hc = 0;
  int m_high = 0;
  bit h1 = 0, h2 = 0, h3 = 0;

  initial begin
    bit rise, to, goodp, clr, sin, fclr;
    int gap;
    forever begin
      @(posedge clk);
      sin  = bus.sync_in;
      fclr = bus.fault_clr;
      n_edge++;
      if (rst) begin
        started = 0; mode = 0; good = 0; m_err = 0; m_period = NOM; m_vld = 0;
        hc = 0; m_high = 0; h1 = 0; h2 = 0; h3 = 0;
      end else begin
        // sync_in sampled two edges ago is what the design sees as "now"
        rise  = h2 && !h3;
        gap   = started ? ((n_edge - last_rise) > 65535 ? 65535 : (n_edge - last_rise)) : 0;
        to    = started && (gap == MAXP + 1) && !rise;
        goodp = (gap >= MINP) && (gap <= MAXP);
        clr   = (mode == 3) && fclr;
        m_vld = 0;
        if (rise && started && !clr) begin
          m_period = gap;
          m_vld    = 1;
          m_high   = hc;
        end
        case (mode)
          0: if (rise) begin mode = 1; good = 0; end
          1: begin
            if (rise) begin
              if (goodp) begin
                good++;
                if (good == LOCKN) mode = 2;
              end else good = 0;
            end else if (to) begin
              mode = 0;
              started = 0;
            end
          end
          2: if ((rise && !goodp) || to) begin
            mode = 3;
            if (m_err < 255) m_err++;
          end
          default: if (fclr) begin mode = 0; good = 0; started = 0; end
        endcase
        if (rise && !clr) begin
          last_rise = n_edge;
          started = 1;
        end
        if (rise) hc = 1;
        else if (h2 && hc < 65535) hc++;
        h3 = h2; h2 = h1; h1 = sin;
      end
      #1;
      chk("locked", bus.locked, mode == 2);
      chk("fault", bus.fault, mode == 3);
      chk("period", bus.period, m_period);
      chk("period_vld", bus.period_vld, m_vld);
      chk("err_cnt", bus.err_cnt, m_err);
`ifdef SYNC_MON_DUTY_EN
      chk("high_time", bus.high_time, m_high);
`endif
    end
  end

  task automatic drive_cycle(input bit s, input bit c);
    @(negedge clk);
    bus.sync_in   = s;
    bus.fault_clr = c;
  endtask

  task automatic drive_span(input int p, input int h, input int i0, input int i1, input int clr_at);
    for (int i = i0; i < i1 && i < p; i++) drive_cycle(i < h, i == clr_at);
  endtask

  task automatic send_period(input int p, input int h);
    drive_span(p, h, 0, p, -1);
  endtask

  // Hold low long enough to time out from any state, then pulse the clear
  task automatic go_idle();
    for (int i = 0; i < 100; i++) drive_cycle(1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0);
  endtask

  initial begin
    int seq_a[11];
    int seq_b[9];
    bus.sync_in   = 1'b0;
    bus.fault_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset locked", bus.locked, 0);
    chk("reset fault", bus.fault, 0);
    chk("reset period", bus.period, 67);
    chk("reset period_vld", bus.period_vld, 0);
    chk("reset err_cnt", bus.err_cnt, 0);
`ifdef SYNC_MON_DUTY_EN
    chk("reset high_time", bus.high_time, 0);
`endif
    rst = 1'b0;

    // 1: nominal 67-cycle sync, lock on the 9th rise
    for (int p = 1; p <= 9; p++) begin
      drive_span(67, 33, 0, 3, -1);
      if (p == 9) chk("t1 not yet locked", bus.locked, 0);
      drive_span(67, 33, 3, 4, -1);
      if (p == 1) chk("t1 first rise no vld", bus.period_vld, 0);
      if (p == 2) begin
        chk("t1 second rise vld", bus.period_vld, 1);
        chk("t1 period", bus.period, 67);
      end
      if (p == 9) chk("t1 locked", bus.locked, 1);
      drive_span(67, 33, 4, 67, -1);
    end
    chk("t1 fault", bus.fault, 0);
    chk("t1 err_cnt", bus.err_cnt, 0);

    // 2: one short period while locked -> sticky fault, then clear and relock
    send_period(59, 29);
    drive_span(67, 33, 0, 4, -1);
    chk("t2 fault", bus.fault, 1);
    chk("t2 locked", bus.locked, 0);
    chk("t2 err_cnt", bus.err_cnt, 1);
    chk("t2 period", bus.period, 59);
    drive_span(67, 33, 4, 67, -1);
    repeat (3) send_period(67, 33);
    chk("t2 fault sticky", bus.fault, 1);
    drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0);
    chk("t2 cleared", bus.fault, 0);
    repeat (10) send_period(67, 33);
    chk("t2 relocked", bus.locked, 1);

    // 3: sync stops while locked -> timeout fault exactly once
    for (int i = 0; i < 150; i++) begin
      drive_cycle(i < 33, 1'b0);
      if (i == 77) chk("t3 fault before timeout", bus.fault, 0);
      if (i == 78) begin
        chk("t3 fault at timeout", bus.fault, 1);
        chk("t3 err_cnt", bus.err_cnt, 2);
      end
    end
    chk("t3 err_cnt held", bus.err_cnt, 2);

    // 4: acquisition restarts after a bad period; boundary periods
    go_idle();
    seq_a = '{67, 67, 80, 67, 67, 67, 67, 67, 67, 67, 67};
    foreach (seq_a[k]) send_period(seq_a[k], seq_a[k] / 2);
    chk("t4 no lock after 7 good", bus.locked, 0);
    send_period(67, 33);
    chk("t4 lock after 8 good", bus.locked, 1);
    go_idle();
    seq_b = '{60, 74, 74, 60, 74, 60, 74, 60, 67};
    foreach (seq_b[k]) send_period(seq_b[k], 30);
    chk("t4 boundary periods lock", bus.locked, 1);
    for (int b = 0; b < 2; b++) begin
      go_idle();
      repeat (5) send_period(67, 33);
      send_period(b == 0 ? 59 : 75, 30);
      repeat (8) send_period(67, 33);
      chk(b == 0 ? "t4 59 rejected" : "t4 75 rejected", bus.locked, 0);
      send_period(67, 33);
      chk("t4 relock after reject", bus.locked, 1);
    end

    // 5: asynchronous reset mid-period, then clear coincident with a bad edge
    drive_span(67, 33, 0, 40, -1);
    #2 rst = 1'b1;
    #1;
    chk("t5 async locked", bus.locked, 0);
    chk("t5 async err_cnt", bus.err_cnt, 0);
    chk("t5 async period", bus.period, 67);
    chk("t5 async fault", bus.fault, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_span(70, 35, 0, 4, -1);
    chk("t5 start edge no vld", bus.period_vld, 0);
    drive_span(70, 35, 4, 70, -1);
    repeat (9) send_period(67, 33);
    chk("t5 relocked", bus.locked, 1);
    send_period(59, 29);
    send_period(67, 33);
    chk("t5 in fault", bus.fault, 1);
    send_period(59, 29);
    drive_span(67, 33, 0, 4, 2);
    chk("t5 clear wins fault", bus.fault, 0);
    chk("t5 clear wins vld", bus.period_vld, 0);
    drive_span(67, 33, 4, 67, -1);

`ifdef SYNC_MON_DUTY_EN
    // 6: duty measurement
    send_period(67, 20);
    drive_span(67, 20, 0, 4, -1);
    chk("t6 high_time", bus.high_time, 20);
    chk("t6 vld", bus.period_vld, 1);
    drive_span(67, 20, 4, 67, -1);
`endif

    // Random periods, duty and clear pulses against the model
    for (int k = 0; k < 40; k++) begin
      int p, h, c;
      p = $urandom_range(82, 55);
      h = $urandom_range(p - 1, 1);
      c = ($urandom_range(7, 0) == 0) ? $urandom_range(p - 1, 0) : -1;
      drive_span(p, h, 0, p, c);
      if (k % 10 == 9) go_idle();
    end
    repeat (5) drive_cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
